// File: rtl/md_pkg.sv
// Shared types for the multiply/divide unit: op encoding, FSM state and
// small op-classification helpers.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MADD  = 4'd5,
    MD_MADDU = 4'd6,
    MD_MSUB  = 4'd7,
    MD_MSUBU = 4'd8,
    MD_MTHI  = 4'd9,
    MD_MTLO  = 4'd10
  } md_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  // True for the two divide opcodes (they use the divide latency).
  function automatic logic md_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for every op that occupies the unit (multiply, accumulate, divide).
  function automatic logic md_is_arith(input md_op_t op);
    return (op >= MD_MULT) && (op <= MD_MSUBU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Issue/read bus between the E stage and the multiply/divide unit.
//
// Handshake: op_valid is the valid and ~busy is the ready. An op transfers on a
// rising clock edge where op_valid & ~busy & ~req; on any other edge op_valid
// has no effect. req kills only an op issued in that same cycle.
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic              op_valid;
  md_pkg::md_op_t    op;
  logic              req;
  logic [WIDTH-1:0]  src_a;
  logic [WIDTH-1:0]  src_b;
  logic              rd_sel;
  logic              busy;
  logic [WIDTH-1:0]  md_out;
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;
  md_pkg::md_state_t state;

  modport master (
    output op_valid, op, req, src_a, src_b, rd_sel,
    input  busy, md_out, hi, lo, state
  );

  modport slave (
    input  op_valid, op, req, src_a, src_b, rd_sel,
    output busy, md_out, hi, lo, state
  );
endinterface

// File: rtl/md_calc.sv
// Combinational arithmetic core: produces the full {HI,LO} result of an op
// from the operands and the current HI/LO, including the divide corner cases.
module md_calc
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_t             op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   hi,
  input  logic [WIDTH-1:0]   lo,
  output logic [2*WIDTH-1:0] res,
  output logic               dz
);

  localparam int W2 = 2 * WIDTH;

  logic             is_signed;
  logic [W2-1:0]    a_ext;
  logic [W2-1:0]    b_ext;
  logic [W2-1:0]    prod;
  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] b_safe;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             min_neg1;

  // Extend operands to 2*WIDTH so one multiplier covers signed and unsigned.
  always_comb begin
    is_signed = (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB) || (op == MD_DIV);
    a_ext     = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    b_ext     = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod      = a_ext * b_ext;
    acc       = {hi, lo};
  end

  // Divide with a zero-safe divisor; MIN/-1 is forced to avoid the overflow.
  always_comb begin
    dz       = md_is_div(op) && (b == '0);
    b_safe   = (b == '0) ? WIDTH'(1) : b;
    min_neg1 = (op == MD_DIV) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    quo      = '0;
    rem      = '0;
    if (op == MD_DIV) begin
      if (min_neg1) begin
        quo = a;
        rem = '0;
      end else begin
        quo = $signed(a) / $signed(b_safe);
        rem = $signed(a) % $signed(b_safe);
      end
    end else begin
      quo = a / b_safe;
      rem = a % b_safe;
    end
  end

  // Select the result; a divide by zero hands back the old HI/LO.
  always_comb begin
    res = acc;
    case (op)
      MD_MULT, MD_MULTU: res = prod;
      MD_MADD, MD_MADDU: res = acc + prod;
      MD_MSUB, MD_MSUBU: res = acc - prod;
      MD_DIV, MD_DIVU:   res = dz ? acc : {rem, quo};
      default:           res = acc;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with the HI/LO register pair. The result is
// computed at issue, held in pend registers, and committed after the op latency.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic       clk,
  input logic       reset,
  md_unit_if.slave  bus
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MUL_LAT = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LAT = CW'(DIV_CYCLES);

  md_state_t          state_q;
  md_state_t          state_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   pend_hi;
  logic [WIDTH-1:0]   pend_lo;
  logic               pend_dz;
  logic               busy;
  logic               commit;
  logic               accept;
  logic               start;
  logic [2*WIDTH-1:0] calc_res;
  logic               calc_dz;

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .op  (bus.op),
    .a   (bus.src_a),
    .b   (bus.src_b),
    .hi  (hi_q),
    .lo  (lo_q),
    .res (calc_res),
    .dz  (calc_dz)
  );

  assign accept = bus.op_valid & ~bus.req & ~busy;
  assign start  = accept & md_is_arith(bus.op);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: run until the counter reaches its last cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == CW'(1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: busy for the whole run, commit on the final edge.
  always_comb begin
    busy   = (state_q == ST_RUN);
    commit = (state_q == ST_RUN) && (cnt_q == CW'(1));
  end

  // Latency counter and pending result, captured at the accepting edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_dz <= 1'b0;
    end else if (start) begin
      cnt_q              <= md_is_div(bus.op) ? DIV_LAT : MUL_LAT;
      {pend_hi, pend_lo} <= calc_res;
      pend_dz            <= calc_dz;
    end else if (busy) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // HI/LO: committed from pend at completion, or written directly by MTHI/MTLO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      if (!pend_dz) begin
        hi_q <= pend_hi;
        lo_q <= pend_lo;
      end
    end else if (accept && (bus.op == MD_MTHI)) begin
      hi_q <= bus.src_a;
    end else if (accept && (bus.op == MD_MTLO)) begin
      lo_q <= bus.src_a;
    end
  end

  assign bus.busy   = busy;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.md_out = bus.rd_sel ? hi_q : lo_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: a 32-bit default instance and a 16-bit instance with
// MUL_CYCLES=1 / DIV_CYCLES=33. Table vectors, hand sequences, and a scoreboard
// queue of expected {HI,LO} values popped when busy drops.
module tb_md_unit;
  import md_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(32)) mb ();
  md_unit_if #(.WIDTH(16)) pb ();

  md_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (mb)
  );

  md_unit #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(33)) u_dut_p (
    .clk   (clk),
    .reset (rst_n),
    .bus   (pb)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  task automatic check_result(input string name, input logic [63:0] act);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: got %h expected <queue empty>", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic v, input md_op_t op, input logic [31:0] a,
                       input logic [31:0] b, input logic rq);
    @(negedge clk);
    mb.op_valid = v;
    mb.op       = op;
    mb.src_a    = a;
    mb.src_b    = b;
    mb.req      = rq;
    @(posedge clk);
    #1;
    mb.op_valid = 1'b0;
    mb.req      = 1'b0;
    mb.op       = MD_NONE;
  endtask

  task automatic p_drive(input md_op_t op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    pb.op_valid = 1'b1;
    pb.op       = op;
    pb.src_a    = a;
    pb.src_b    = b;
    @(posedge clk);
    #1;
    pb.op_valid = 1'b0;
    pb.op       = MD_NONE;
  endtask

  // Count negedges with busy high until it drops; bounded.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!mb.busy) break;
      n++;
    end
  endtask

  task automatic p_wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!pb.busy) break;
      n++;
    end
  endtask

  task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int cyc,
                        input string name);
    int n;
    exp_q.push_back({eh, el});
    drive(1'b1, op, a, b, 1'b0);
    wait_idle(n);
    check({name, "_busy_cycles"}, 64'(n), 64'(cyc));
    check_result(name, {mb.hi, mb.lo});
  endtask

  task automatic p_run(input md_op_t op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eh, input logic [15:0] el, input int cyc,
                       input string name);
    int n;
    exp_q.push_back(64'({eh, el}));
    p_drive(op, a, b);
    p_wait_idle(n);
    check({name, "_busy_cycles"}, 64'(n), 64'(cyc));
    check_result(name, 64'({pb.hi, pb.lo}));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    md_op_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int n;
    logic [31:0] ra, rb;
    logic [63:0] rp;

    vecs[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'd5,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFE, 32'h00000001, 5};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{MD_DIVU,  32'd7,        32'd0,        32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 10};
    vecs[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h1,        32'h1,        32'h00000000, 32'h80000000, 10};
    vecs[5]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFD, 10};
    vecs[6]  = '{MD_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0,        32'h0,        32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[7]  = '{MD_MADDU, 32'd1,        32'd1,        32'h0,        32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5};
    vecs[8]  = '{MD_MSUB,  32'd1,        32'd1,        32'h1,        32'h0,        32'h00000000, 32'hFFFFFFFF, 5};
    vecs[9]  = '{MD_MADD,  32'hFFFFFFFE, 32'd3,        32'h0,        32'h10,       32'h00000000, 32'h0000000A, 5};
    vecs[10] = '{MD_MSUBU, 32'd2,        32'd3,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[11] = '{MD_DIV,   32'd5,        32'd0,        32'h1,        32'h2,        32'h00000001, 32'h00000002, 10};

    mb.op_valid = 1'b0; mb.op = MD_NONE; mb.req = 1'b0;
    mb.src_a = '0; mb.src_b = '0; mb.rd_sel = 1'b0;
    pb.op_valid = 1'b0; pb.op = MD_NONE; pb.req = 1'b0;
    pb.src_a = '0; pb.src_b = '0; pb.rd_sel = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("reset_busy",   64'(mb.busy),   64'(0));
    check("reset_hi",     64'(mb.hi),     64'(0));
    check("reset_lo",     64'(mb.lo),     64'(0));
    check("reset_md_out", 64'(mb.md_out), 64'(0));
    check("reset_state",  64'(mb.state),  64'(ST_IDLE));

    // Table vectors, each with preloaded HI/LO
    for (int i = 0; i < 12; i++) begin
      mb.rd_sel = i[0];
      drive(1'b1, MD_MTHI, vecs[i].pre_hi, 32'h0, 1'b0);
      drive(1'b1, MD_MTLO, vecs[i].pre_lo, 32'h0, 1'b0);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
             vecs[i].cyc, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_md_out", i), 64'(mb.md_out),
            64'(i[0] ? vecs[i].exp_hi : vecs[i].exp_lo));
    end
    mb.rd_sel = 1'b0;

    // MADDU then MSUB, accumulate reading the committed value
    drive(1'b1, MD_MTHI, 32'h0, 32'h0, 1'b0);
    drive(1'b1, MD_MTLO, 32'hFFFFFFFF, 32'h0, 1'b0);
    run_op(MD_MADDU, 32'd1, 32'd1, 32'h1, 32'h0, 5, "seq_maddu");
    run_op(MD_MSUB,  32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 5, "seq_msub");

    // req kills an op issued in the same cycle
    drive(1'b1, MD_MTHI, 32'h11, 32'h0, 1'b0);
    drive(1'b1, MD_MTLO, 32'h22, 32'h0, 1'b0);
    drive(1'b1, MD_MULT, 32'd3, 32'd3, 1'b1);
    @(negedge clk);
    check("req_kill_busy", 64'(mb.busy), 64'(0));
    repeat (6) @(negedge clk);
    check("req_kill_hilo", {mb.hi, mb.lo}, {32'h11, 32'h22});

    // Second MULT while busy is ignored
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFF1});
    drive(1'b1, MD_MULT, 32'hFFFFFFFD, 32'd5, 1'b0);
    drive(1'b1, MD_MULT, 32'd7, 32'd7, 1'b0);
    wait_idle(n);
    check("ignored_busy_remaining", 64'(n), 64'(4));
    check_result("ignored_result", {mb.hi, mb.lo});

    // req pulsed mid-run does not abort
    exp_q.push_back({32'd2, 32'd14});
    drive(1'b1, MD_DIVU, 32'd100, 32'd7, 1'b0);
    drive(1'b0, MD_NONE, 32'h0, 32'h0, 1'b1);
    wait_idle(n);
    check("req_midrun_busy_remaining", 64'(n), 64'(9));
    check_result("req_midrun_result", {mb.hi, mb.lo});

    // Random unsigned multiplies and divides against a reference model
    for (int i = 0; i < 4; i++) begin
      ra = $urandom_range(32'hFFFFFFFF, 0);
      rb = $urandom_range(32'hFFFFFFFF, 0);
      rp = {32'h0, ra} * {32'h0, rb};
      run_op(MD_MULTU, ra, rb, rp[63:32], rp[31:0], 5, $sformatf("rnd_multu%0d", i));
      rb = $urandom_range(32'h0000FFFF, 1);
      run_op(MD_DIVU, ra, rb, ra % rb, ra / rb, 10, $sformatf("rnd_divu%0d", i));
    end

    // Reset during cycle 3 of a DIV
    drive(1'b1, MD_MTHI, 32'hAAAA, 32'h0, 1'b0);
    drive(1'b1, MD_MTLO, 32'h5555, 32'h0, 1'b0);
    drive(1'b1, MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",   64'(mb.busy),   64'(0));
    check("midrst_hilo",   {mb.hi, mb.lo}, 64'(0));
    check("midrst_md_out", 64'(mb.md_out), 64'(0));
    check("midrst_state",  64'(mb.state),  64'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_late_commit", {mb.hi, mb.lo}, 64'(0));
    drive(1'b1, MD_MTLO, 32'd5, 32'h0, 1'b0);
    @(negedge clk);
    check("mtlo_md_out_lo", 64'(mb.md_out), 64'(5));
    mb.rd_sel = 1'b1;
    @(negedge clk);
    check("mtlo_md_out_hi", 64'(mb.md_out), 64'(0));

    // Parametrised instance: WIDTH=16, MUL_CYCLES=1, DIV_CYCLES=33
    p_run(MD_MULT,  16'hFFFD, 16'd5,    16'hFFFF, 16'hFFF1, 1,  "p_mult");
    p_run(MD_DIV,   16'hFFF9, 16'd2,    16'hFFFF, 16'hFFFD, 33, "p_div");
    p_run(MD_MULTU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1,  "p_multu");
    p_run(MD_DIVU,  16'h1234, 16'h0010, 16'h0004, 16'h0123, 33, "p_divu");

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
